// File: rtl/tick_timeout_pkg.sv
// Shared types and defaults for the prescaled-tick timeout counter and its
// consumers in the AXI monitor.
package tick_timeout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPIRED
  } tto_state_e;

  localparam int unsigned TtoDefaultCntWidth = 8;

endpackage

// File: rtl/toggle_edge_detect.sv
// Two-flop edge detector that turns the prescaler's toggling level into a
// one-cycle tick. The tick is decoded from flops only.
module toggle_edge_detect #(
  parameter bit RisingOnly = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic tick_o
);

  logic p_q;
  logic p_qq;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q  <= 1'b0;
      p_qq <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make p_qq take the old p_q, forming a
      // true two-stage shift; blocking here would collapse it into one stage.
      p_q  <= level_i;
      p_qq <= p_q;
    end
  end

  assign tick_o = RisingOnly ? (p_q & ~p_qq) : (p_q ^ p_qq);

endmodule

// File: rtl/tick_timeout_counter.sv
// Counts prescaled ticks down from a loaded budget and raises a sticky
// timeout when the budget is exhausted. One instance guards one transaction.
module tick_timeout_counter
  import tick_timeout_pkg::*;
#(
  parameter int unsigned CntWidth   = TtoDefaultCntWidth,
  parameter bit          RisingOnly = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                prescaled_i,
  input  logic                start_i,
  input  logic [CntWidth-1:0] budget_i,
  input  logic                stop_i,
  input  logic                clear_i,
  output logic                tick_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [CntWidth-1:0] remaining_o
);

  tto_state_e          state_q;
  logic [CntWidth-1:0] remaining_q;
  logic                tick;

  toggle_edge_detect #(
    .RisingOnly(RisingOnly)
  ) u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .level_i(prescaled_i),
    .tick_o (tick)
  );

  // A tick coinciding with stop or start is dropped by the priority order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            remaining_q <= budget_i;
            state_q     <= (budget_i == '0) ? EXPIRED : COUNT;
          end
        end
        COUNT: begin
          if (stop_i) begin
            state_q <= IDLE;
          end else if (start_i) begin
            remaining_q <= budget_i;
            state_q     <= (budget_i == '0) ? EXPIRED : COUNT;
          end else if (tick) begin
            // The 1->0 step leaves COUNT, so the decrement can never wrap.
            if (remaining_q <= CntWidth'(1)) begin
              remaining_q <= '0;
              state_q     <= EXPIRED;
            end else begin
              remaining_q <= remaining_q - CntWidth'(1);
            end
          end
        end
        EXPIRED: begin
          if (clear_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tick_o      = tick;
  assign busy_o      = (state_q == COUNT);
  assign timeout_o   = (state_q == EXPIRED);
  assign remaining_o = remaining_q;

endmodule

// File: tb/tb_tick_timeout_counter.sv
// Directed bench for tick_timeout_counter: a per-cycle vector table plus
// hand-written multi-cycle sequences on three parameterisations.
module tb_tick_timeout_counter;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       prescaled = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] budget = 8'd0;

  logic       tick0, busy0, tout0;
  logic [7:0] rem0;
  logic       tick1, busy1, tout1;
  logic [7:0] rem1;
  logic       tick2, busy2, tout2;
  logic [3:0] rem2;

  int checks = 0;
  int errors = 0;
  bit gen_en = 1'b0;
  int pcnt = 0;

  always #5 clk = ~clk;

  tick_timeout_counter #(.CntWidth(8), .RisingOnly(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .prescaled_i(prescaled), .start_i(start),
    .budget_i(budget), .stop_i(stop), .clear_i(clear),
    .tick_o(tick0), .busy_o(busy0), .timeout_o(tout0), .remaining_o(rem0)
  );

  tick_timeout_counter #(.CntWidth(8), .RisingOnly(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .prescaled_i(prescaled), .start_i(start),
    .budget_i(budget), .stop_i(stop), .clear_i(clear),
    .tick_o(tick1), .busy_o(busy1), .timeout_o(tout1), .remaining_o(rem1)
  );

  tick_timeout_counter #(.CntWidth(4), .RisingOnly(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .prescaled_i(prescaled), .start_i(start),
    .budget_i(budget[3:0]), .stop_i(stop), .clear_i(clear),
    .tick_o(tick2), .busy_o(busy2), .timeout_o(tout2), .remaining_o(rem2)
  );

  typedef struct {
    logic       p;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] budget;
    logic       tick;
    logic       busy;
    logic       tout;
    logic [7:0] rem;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic p, input logic st, input logic sp,
                              input logic cl, input logic [7:0] bud,
                              input logic tk, input logic bs, input logic to,
                              input logic [7:0] rm);
    vec_t v;
    v.p = p; v.start = st; v.stop = sp; v.clear = cl; v.budget = bud;
    v.tick = tk; v.busy = bs; v.tout = to; v.rem = rm;
    return v;
  endfunction

  function automatic logic get_tick(input int s);
    case (s)
      0:       return tick0;
      1:       return tick1;
      default: return tick2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; inputs change 1 time unit after the edge, outputs are read there too.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (gen_en) begin
      pcnt++;
      if (pcnt == D) begin
        prescaled = ~prescaled;
        pcnt = 0;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; budget = 8'd0;
    prescaled = 1'b0; gen_en = 1'b0; pcnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_tick(input int s);
    int n = 0;
    while (!get_tick(s) && n < 40) begin
      cyc();
      n++;
    end
    check("tick_wait", 32'(get_tick(s)), 32'd1);
  endtask

  // Wait for a visible tick, then clock it into the counter.
  task automatic consume_tick(input int s);
    wait_tick(s);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;

    // Table: budget 3 with D=4 toggles, expiry, zero budget, clear behaviour.
    vecs[0]  = mk(0, 1, 0, 0, 8'd3, 0, 1, 0, 8'd3);
    vecs[1]  = mk(1, 0, 0, 0, 8'd0, 1, 1, 0, 8'd3);
    vecs[2]  = mk(1, 0, 0, 0, 8'd0, 0, 1, 0, 8'd2);
    vecs[3]  = mk(1, 0, 0, 0, 8'd0, 0, 1, 0, 8'd2);
    vecs[4]  = mk(1, 0, 0, 0, 8'd0, 0, 1, 0, 8'd2);
    vecs[5]  = mk(0, 0, 0, 0, 8'd0, 1, 1, 0, 8'd2);
    vecs[6]  = mk(0, 0, 0, 0, 8'd0, 0, 1, 0, 8'd1);
    vecs[7]  = mk(0, 0, 0, 0, 8'd0, 0, 1, 0, 8'd1);
    vecs[8]  = mk(0, 0, 0, 0, 8'd0, 0, 1, 0, 8'd1);
    vecs[9]  = mk(1, 0, 0, 0, 8'd0, 1, 1, 0, 8'd1);
    vecs[10] = mk(1, 0, 0, 0, 8'd0, 0, 0, 1, 8'd0);
    vecs[11] = mk(1, 0, 0, 0, 8'd0, 0, 0, 1, 8'd0);
    vecs[12] = mk(1, 0, 0, 1, 8'd0, 0, 0, 0, 8'd0);
    vecs[13] = mk(1, 1, 0, 0, 8'd0, 0, 0, 1, 8'd0);
    vecs[14] = mk(0, 1, 0, 0, 8'd5, 1, 0, 1, 8'd0);
    vecs[15] = mk(0, 1, 0, 1, 8'd5, 0, 0, 0, 8'd0);
    vecs[16] = mk(0, 0, 1, 0, 8'd0, 0, 0, 0, 8'd0);

    reset_dut();
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_timeout", 32'(tout0), 32'd0);
    check("reset_remaining", 32'(rem0), 32'd0);
    check("reset_tick", 32'(tick0), 32'd0);

    for (int i = 0; i < 17; i++) begin
      prescaled = vecs[i].p;
      start = vecs[i].start;
      stop = vecs[i].stop;
      clear = vecs[i].clear;
      budget = vecs[i].budget;
      cyc();
      check($sformatf("vec%0d_tick", i), 32'(tick0), 32'(vecs[i].tick));
      check($sformatf("vec%0d_busy", i), 32'(busy0), 32'(vecs[i].busy));
      check($sformatf("vec%0d_timeout", i), 32'(tout0), 32'(vecs[i].tout));
      check($sformatf("vec%0d_remaining", i), 32'(rem0), 32'(vecs[i].rem));
    end
    stop = 1'b0;

    // Stop in the same cycle as the 2nd tick: tick dropped, no timeout.
    reset_dut();
    gen_en = 1'b1;
    start = 1'b1; budget = 8'd2;
    cyc();
    start = 1'b0;
    consume_tick(0);
    check("stop_rem_after_1st", 32'(rem0), 32'd1);
    wait_tick(0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_busy", 32'(busy0), 32'd0);
    check("stop_timeout", 32'(tout0), 32'd0);
    check("stop_remaining", 32'(rem0), 32'd1);
    for (int i = 0; i < 12; i++) cyc();
    check("stop_no_late_timeout", 32'(tout0), 32'd0);

    // Restart mid-count reloads the budget.
    reset_dut();
    gen_en = 1'b1;
    start = 1'b1; budget = 8'd5;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) consume_tick(0);
    check("restart_rem_before", 32'(rem0), 32'd2);
    start = 1'b1; budget = 8'd4;
    cyc();
    start = 1'b0;
    check("restart_rem_loaded", 32'(rem0), 32'd4);
    check("restart_busy", 32'(busy0), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      consume_tick(0);
      if (i < 4) begin
        check($sformatf("restart_rem_%0d", i), 32'(rem0), 32'(4 - i));
        check($sformatf("restart_no_timeout_%0d", i), 32'(tout0), 32'd0);
      end else begin
        check("restart_timeout", 32'(tout0), 32'd1);
        check("restart_rem_zero", 32'(rem0), 32'd0);
        check("restart_busy_low", 32'(busy0), 32'd0);
      end
    end

    // Rising-only: ticks every 2*D cycles, expiry after budget 2.
    reset_dut();
    gen_en = 1'b1;
    start = 1'b1; budget = 8'd2;
    cyc();
    start = 1'b0;
    consume_tick(1);
    check("rise_rem_1", 32'(rem1), 32'd1);
    gap = 1;
    while (!tick1 && gap < 20) begin
      cyc();
      gap++;
    end
    check("rise_gap", 32'(gap), 32'd8);
    cyc();
    check("rise_timeout", 32'(tout1), 32'd1);
    check("rise_rem_zero", 32'(rem1), 32'd0);
    check("rise_busy_low", 32'(busy1), 32'd0);

    // Asynchronous reset mid-count discards everything.
    reset_dut();
    gen_en = 1'b1;
    start = 1'b1; budget = 8'd5;
    cyc();
    start = 1'b0;
    consume_tick(1);
    consume_tick(1);
    check("midrst_rem_before", 32'(rem1), 32'd3);
    rst = 1'b1;
    #2;
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_timeout", 32'(tout1), 32'd0);
    check("midrst_remaining", 32'(rem1), 32'd0);
    check("midrst_tick", 32'(tick1), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) cyc();
    check("midrst_no_timeout", 32'(tout1), 32'd0);
    check("midrst_still_idle", 32'(busy1), 32'd0);

    // Narrow counter: budget 15 counts down to 0 without wrapping.
    reset_dut();
    gen_en = 1'b1;
    start = 1'b1; budget = 8'd15;
    cyc();
    start = 1'b0;
    check("w4_rem_loaded", 32'(rem2), 32'd15);
    for (int i = 1; i <= 15; i++) begin
      consume_tick(2);
      check($sformatf("w4_rem_%0d", i), 32'(rem2), 32'(15 - i));
    end
    check("w4_timeout", 32'(tout2), 32'd1);
    for (int i = 0; i < 3; i++) consume_tick(2);
    check("w4_rem_held_zero", 32'(rem2), 32'd0);
    check("w4_timeout_sticky", 32'(tout2), 32'd1);
    check("w4_busy_low", 32'(busy2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
